// File: rtl/rtc_lap_controller.sv
// Run/lap sequencer: decodes button pulses into counter controls, stores laps, picks display source.
// Latency: state and controls 1 cycle after the pulse; o_disp_count 1 cycle after its selected source.
// Backpressure: none; pulses are consumed in the cycle they arrive, illegal or lower-priority ones dropped.
//
// Optional feature macro: RTC_LAP_RECALL_EN
//   defined   -> DEPTH-entry lap buffer, RECALL state, i_recall stepping.
//   undefined -> single hold register only; lap count/index/full tied to 0, i_recall ignored.
//
// Ports:
//   i_sclk, i_reset          clock, synchronous active-high reset
//   i_start_stop, i_lap,     single-cycle button pulses
//   i_clear, i_recall
//   i_count[23:0]            live BCD count from the counter
//   o_count_enb              counter enable (high only in RUN)
//   o_count_init             one-cycle counter zero request on clear
//   o_latch_count            high while a lap hold is active
//   o_disp_count[23:0]       registered display value
//   o_state[1:0]             IDLE=0 RUN=1 STOP=2 RECALL=3
//   o_lap_num, o_lap_idx,    stored lap count, recalled index, buffer full
//   o_full
module rtc_lap_controller #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                     i_sclk,
    input  logic                     i_reset,
    input  logic                     i_start_stop,
    input  logic                     i_lap,
    input  logic                     i_clear,
    input  logic                     i_recall,
    input  logic [23:0]              i_count,
    output logic                     o_count_enb,
    output logic                     o_count_init,
    output logic                     o_latch_count,
    output logic [23:0]              o_disp_count,
    output logic [1:0]               o_state,
    output logic [$clog2(DEPTH):0]   o_lap_num,
    output logic [$clog2(DEPTH)-1:0] o_lap_idx,
    output logic                     o_full
);

    localparam int IW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STOP   = 2'd2,
        ST_RECALL = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_count_enb;
    logic           r_count_init;
    logic [HW-1:0]  r_hold;
    logic [23:0]    r_held;
    logic [23:0]    r_disp;

    // Buffer-side status, driven by the configurable section below.
    logic           w_full;
    logic           w_have_laps;
    logic [23:0]    w_recall_dat;

    // Decoded actions: at most one is high per cycle.
    logic           w_start;
    logic           w_stop;
    logic           w_lap_cap;
    logic           w_clear;
    logic           w_recall_enter;
    logic           w_recall_step;

    // Each state only looks at its legal pulses, in priority order
    // clear > start_stop > lap > recall, so an illegal higher-priority
    // pulse never masks a legal lower-priority one.
    always_comb begin
        w_start        = 1'b0;
        w_stop         = 1'b0;
        w_lap_cap      = 1'b0;
        w_clear        = 1'b0;
        w_recall_enter = 1'b0;
        w_recall_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = i_start_stop;
            end
            ST_RUN: begin
                if (i_start_stop)
                    w_stop = 1'b1;
                else if (i_lap && !w_full)
                    w_lap_cap = 1'b1;
            end
            ST_STOP: begin
                if (i_clear)
                    w_clear = 1'b1;
                else if (i_start_stop)
                    w_start = 1'b1;
                else if (i_recall && w_have_laps)
                    w_recall_enter = 1'b1;
            end
            ST_RECALL: begin
                if (i_clear)
                    w_clear = 1'b1;
                else if (i_start_stop)
                    w_start = 1'b1;
                else if (i_recall)
                    w_recall_step = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count_enb  <= 1'b0;
            r_count_init <= 1'b0;
            r_hold       <= '0;
            r_held       <= '0;
            r_disp       <= '0;
        end else begin
            r_count_init <= w_clear;

            if (w_start) begin
                r_state     <= ST_RUN;
                r_count_enb <= 1'b1;
            end else if (w_stop) begin
                r_state     <= ST_STOP;
                r_count_enb <= 1'b0;
            end else if (w_clear) begin
                r_state <= ST_IDLE;
            end else if (w_recall_enter) begin
                r_state <= ST_RECALL;
            end

            // Stop cancels a hold; a new lap (re)loads it to the full period.
            if (w_stop)
                r_hold <= '0;
            else if (w_lap_cap)
                r_hold <= HOLD_LOAD;
            else if (r_hold != '0)
                r_hold <= r_hold - 1'b1;

            if (w_lap_cap)
                r_held <= i_count;

            // Source is chosen from this cycle's registered state/hold.
            if (r_state == ST_RECALL)
                r_disp <= w_recall_dat;
            else if (r_hold != '0)
                r_disp <= r_held;
            else
                r_disp <= i_count;
        end
    end

`ifdef RTC_LAP_RECALL_EN
    localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

    logic [IW:0]   r_lap_num;
    logic [IW-1:0] r_lap_idx;
    logic [23:0]   r_buf [DEPTH];

    assign w_full       = (r_lap_num == DEPTH_W);
    assign w_have_laps  = (r_lap_num != '0);
    assign w_recall_dat = r_buf[r_lap_idx];

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_lap_num <= '0;
            r_lap_idx <= '0;
        end else begin
            if (w_clear)
                r_lap_num <= '0;
            else if (w_lap_cap)
                r_lap_num <= r_lap_num + 1'b1;

            if (w_clear || w_recall_enter)
                r_lap_idx <= '0;
            else if (w_recall_step) begin
                if ({1'b0, r_lap_idx} == r_lap_num - 1'b1)
                    r_lap_idx <= '0;
                else
                    r_lap_idx <= r_lap_idx + 1'b1;
            end
        end
    end

    // Buffer contents need no reset: entries are only read below r_lap_num.
    always_ff @(posedge i_sclk) begin
        if (w_lap_cap)
            r_buf[r_lap_num[IW-1:0]] <= i_count;
    end

    assign o_lap_num = r_lap_num;
    assign o_lap_idx = r_lap_idx;
    assign o_full    = w_full;
`else
    // No buffer: laps are unlimited, recall can never be entered.
    assign w_full       = 1'b0;
    assign w_have_laps  = 1'b0;
    assign w_recall_dat = 24'h0;

    assign o_lap_num = '0;
    assign o_lap_idx = '0;
    assign o_full    = 1'b0;
`endif

    assign o_state       = r_state;
    assign o_count_enb   = r_count_enb;
    assign o_count_init  = r_count_init;
    assign o_latch_count = (r_hold != '0);
    assign o_disp_count  = r_disp;

endmodule

// File: tb/tb_rtc_lap_controller.sv
// Directed bench for rtc_lap_controller with DEPTH=4, HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Expectations follow the build: buffer/recall behaviour only when RTC_LAP_RECALL_EN is defined.
module tb_rtc_lap_controller;

`ifdef RTC_LAP_RECALL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        i_sclk;
    logic        i_reset;
    logic        i_start_stop;
    logic        i_lap;
    logic        i_clear;
    logic        i_recall;
    logic [23:0] i_count;
    logic        o_count_enb;
    logic        o_count_init;
    logic        o_latch_count;
    logic [23:0] o_disp_count;
    logic [1:0]  o_state;
    logic [2:0]  o_lap_num;
    logic [1:0]  o_lap_idx;
    logic        o_full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] exp_buf [4];
    logic [23:0] lap_vals [3];

    rtc_lap_controller #(
        .DEPTH       (4),
        .HOLD_CYCLES (4)
    ) dut (
        .i_sclk        (i_sclk),
        .i_reset       (i_reset),
        .i_start_stop  (i_start_stop),
        .i_lap         (i_lap),
        .i_clear       (i_clear),
        .i_recall      (i_recall),
        .i_count       (i_count),
        .o_count_enb   (o_count_enb),
        .o_count_init  (o_count_init),
        .o_latch_count (o_latch_count),
        .o_disp_count  (o_disp_count),
        .o_state       (o_state),
        .o_lap_num     (o_lap_num),
        .o_lap_idx     (o_lap_idx),
        .o_full        (o_full)
    );

    initial i_sclk = 1'b0;
    always #5 i_sclk = ~i_sclk;

    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    initial begin
        exp_buf[0]  = 24'h000123;
        exp_buf[1]  = 24'h000222;
        exp_buf[2]  = 24'h000333;
        exp_buf[3]  = 24'h000444;
        lap_vals[0] = 24'h000222;
        lap_vals[1] = 24'h000333;
        lap_vals[2] = 24'h000444;

        i_reset = 1'b1; i_start_stop = 1'b0; i_lap = 1'b0;
        i_clear = 1'b0; i_recall = 1'b0; i_count = 24'h0;
        tick(); tick();

        // Reset state
        chk("rst_state", o_state, 0);
        chk("rst_enb", o_count_enb, 0);
        chk("rst_init", o_count_init, 0);
        chk("rst_latch", o_latch_count, 0);
        chk("rst_disp", o_disp_count, 0);
        chk("rst_lapnum", o_lap_num, 0);
        chk("rst_idx", o_lap_idx, 0);
        chk("rst_full", o_full, 0);
        i_reset = 1'b0;
        tick();

        // Start
        i_start_stop = 1'b1; tick(); i_start_stop = 1'b0;
        chk("start_state", o_state, 1);
        chk("start_enb", o_count_enb, 1);
        chk("start_init", o_count_init, 0);
        chk("start_latch", o_latch_count, 0);
        chk("start_lapnum", o_lap_num, 0);

        // Lap hold: captured in cycle N, held N+1..N+4
        i_count = 24'h000123; i_lap = 1'b1; tick(); i_lap = 1'b0;
        i_count = 24'h000456;
        chk("hold_latch_1", o_latch_count, 1);
        chk("hold_disp_1", o_disp_count, 24'h000123);
        chk("hold_lapnum", o_lap_num, EN ? 1 : 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("hold_latch_%0d", k), o_latch_count, 1);
            chk($sformatf("hold_disp_%0d", k), o_disp_count, 24'h000123);
        end
        tick();
        chk("hold_latch_end", o_latch_count, 0);
        chk("hold_disp_end", o_disp_count, 24'h000123);
        tick();
        chk("disp_follow", o_disp_count, 24'h000456);

        // Fill the buffer
        for (int k = 0; k < 3; k++) begin
            i_count = lap_vals[k]; i_lap = 1'b1; tick(); i_lap = 1'b0;
            chk($sformatf("fill_lapnum_%0d", k), o_lap_num, EN ? k + 2 : 0);
            chk($sformatf("fill_latch_%0d", k), o_latch_count, 1);
        end
        chk("fill_full", o_full, EN ? 1 : 0);
        for (int k = 0; k < 5; k++) tick();
        chk("fill_hold_done", o_latch_count, 0);
        // Fifth lap: ignored when full, captured when unbuffered
        i_count = 24'h000555; i_lap = 1'b1; tick(); i_lap = 1'b0;
        chk("lap5_latch", o_latch_count, EN ? 0 : 1);
        chk("lap5_lapnum", o_lap_num, EN ? 4 : 0);
        chk("lap5_disp", o_disp_count, 24'h000555);

        // Stop cancels any hold
        i_count = 24'h000777;
        i_start_stop = 1'b1; tick(); i_start_stop = 1'b0;
        chk("stop_state", o_state, 2);
        chk("stop_enb", o_count_enb, 0);
        chk("stop_latch", o_latch_count, 0);

        // Recall x5 with wrap
        for (int k = 0; k < 5; k++) begin
            i_recall = 1'b1; tick(); i_recall = 1'b0;
            chk($sformatf("rcl_state_%0d", k), o_state, EN ? 3 : 2);
            chk($sformatf("rcl_idx_%0d", k), o_lap_idx, EN ? k % 4 : 0);
            tick();
            chk($sformatf("rcl_disp_%0d", k), o_disp_count, EN ? exp_buf[k % 4] : 24'h000777);
        end

        // Back to STOP via RUN
        i_start_stop = 1'b1; tick(); i_start_stop = 1'b0;
        chk("resume_state", o_state, 1);
        chk("resume_lapnum", o_lap_num, EN ? 4 : 0);
        i_start_stop = 1'b1; tick(); i_start_stop = 1'b0;
        chk("restop_state", o_state, 2);

        // Clear beats start_stop
        i_clear = 1'b1; i_start_stop = 1'b1; tick();
        i_clear = 1'b0; i_start_stop = 1'b0;
        chk("clr_state", o_state, 0);
        chk("clr_init", o_count_init, 1);
        chk("clr_enb", o_count_enb, 0);
        chk("clr_lapnum", o_lap_num, 0);
        chk("clr_full", o_full, 0);
        tick();
        chk("clr_init_off", o_count_init, 0);
        chk("clr_state_hold", o_state, 0);

        // Reset mid-hold
        i_start_stop = 1'b1; tick(); i_start_stop = 1'b0;
        i_count = 24'h000999; i_lap = 1'b1; tick(); i_lap = 1'b0;
        chk("mh_latch", o_latch_count, 1);
        chk("mh_lapnum", o_lap_num, EN ? 1 : 0);
        tick();
        i_reset = 1'b1; tick();
        chk("mh_rst_latch", o_latch_count, 0);
        chk("mh_rst_disp", o_disp_count, 0);
        chk("mh_rst_state", o_state, 0);
        chk("mh_rst_enb", o_count_enb, 0);
        chk("mh_rst_lapnum", o_lap_num, 0);
        chk("mh_rst_init", o_count_init, 0);
        i_reset = 1'b0; tick();
        chk("mh_post_init", o_count_init, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
